datapath_gen: RTL and testbench

Parametrised next-generation SLC3 datapath: same bus-gated, control-signal-driven structure as the current datapath, generalised to word width W. Extended ALU with shifts and XOR. Adds an iterative shift-add multiplier with a start/busy/done handshake and a registered bus-conflict detector. Sits between the SLC3 control FSM and the memory/IO interface.

---
 rtl/datapath_gen_pkg.sv | 43 ++++
 rtl/seq_mul.sv | 90 +++++++++
 rtl/datapath_gen.sv | 185 ++++++++++++++++++
 tb/tb_datapath_gen.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_gen_pkg.sv
// Shared encodings for the parametrised SLC3 datapath: ALU ops, mux selects,
// condition codes and multiplier states.
package datapath_gen_pkg;

    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned REG_SEL_W = 3;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_AND  = 3'd1,
        ALU_NOT  = 3'd2,
        ALU_PASS = 3'd3,
        ALU_SHL  = 3'd4,
        ALU_SHR  = 3'd5,
        ALU_SRA  = 3'd6,
        ALU_XOR  = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_INC  = 2'd0,
        PC_ADDR = 2'd1,
        PC_BUS  = 2'd2,
        PC_ZERO = 2'd3
    } pcmux_e;

    typedef enum logic [1:0] {
        A2_ZERO  = 2'd0,
        A2_OFF6  = 2'd1,
        A2_OFF9  = 2'd2,
        A2_OFF11 = 2'd3
    } addr2mux_e;

    localparam logic [2:0] CC_NEG  = 3'b100;
    localparam logic [2:0] CC_ZERO = 3'b010;
    localparam logic [2:0] CC_POS  = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/seq_mul.sv
// Iterative shift-add multiplier, one multiplier bit per cycle LSB first;
// returns the low W bits of the unsigned product with a start/busy/done handshake.
module seq_mul
    import datapath_gen_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result
);

    localparam int unsigned CNT_W = $clog2(W);

    mul_state_e     state_q, state_d;
    logic [W-1:0]   mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   acc_add;
    logic [W-1:0]   result_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic           busy_d, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result   <= result_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    // Start is accepted in IDLE and in the DONE cycle; ignored while running.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result;
        acc_add  = acc_q + (mplier_q[0] ? mcand_q : '0);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_RUN;
                    mcand_d  = a;
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d    = acc_add;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(W - 1)) begin
                    state_d  = ST_DONE;
                    result_d = acc_add;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

endmodule

// File: rtl/datapath_gen.sv
// Parametrised SLC3 datapath: gated bus, register file, extended ALU,
// address adder, condition codes, branch enable and a sequential multiplier.
module datapath_gen
    import datapath_gen_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         LD_MAR,
    input  logic         LD_MDR,
    input  logic         LD_IR,
    input  logic         LD_BEN,
    input  logic         LD_CC,
    input  logic         LD_REG,
    input  logic         LD_PC,
    input  logic         LD_LED,
    input  logic         GatePC,
    input  logic         GateMDR,
    input  logic         GateALU,
    input  logic         GateMARMUX,
    input  logic         GateMUL,
    input  logic         SR2MUX,
    input  logic         ADDR1MUX,
    input  logic         DRMUX,
    input  logic         SR1MUX,
    input  logic         MIO_EN,
    input  logic [1:0]   PCMUX,
    input  logic [1:0]   ADDR2MUX,
    input  logic [2:0]   ALUK,
    input  logic         MUL_START,
    input  logic [W-1:0] MDR_In,
    output logic [W-1:0] MAR,
    output logic [W-1:0] MDR,
    output logic [W-1:0] PC,
    output logic [W-1:0] IR,
    output logic         BEN,
    output logic [9:0]   LED,
    output logic         MUL_BUSY,
    output logic         MUL_DONE,
    output logic         BUS_CONFLICT
);

    localparam int unsigned SH_W = $clog2(W);

    logic [W-1:0]         regs [NUM_REGS];
    logic [REG_SEL_W-1:0] sr1_sel, sr2_sel, dr_sel;
    logic [W-1:0]         sr1_val, sr2_val;
    logic [W-1:0]         alu_b, alu_out;
    logic [SH_W-1:0]      shamt;
    logic [W-1:0]         addr1, addr2, addr_sum;
    logic [W-1:0]         pc_next, mdr_next, bus, mul_result;
    logic [W-1:0]         sext5, sext6, sext9, sext11;
    logic [4:0]           gates;
    logic [2:0]           gate_cnt;
    logic                 multi_gate;
    logic [2:0]           cc_q, cc_d;

    assign sext5  = {{(W-5){IR[4]}},   IR[4:0]};
    assign sext6  = {{(W-6){IR[5]}},   IR[5:0]};
    assign sext9  = {{(W-9){IR[8]}},   IR[8:0]};
    assign sext11 = {{(W-11){IR[10]}}, IR[10:0]};

    assign sr1_sel = SR1MUX ? IR[11:9] : IR[8:6];
    assign sr2_sel = IR[2:0];
    assign dr_sel  = DRMUX ? IR[11:9] : 3'd7;
    assign sr1_val = regs[sr1_sel];
    assign sr2_val = regs[sr2_sel];
    assign alu_b   = SR2MUX ? sext5 : sr2_val;
    assign shamt   = alu_b[SH_W-1:0];

    always_comb begin
        alu_out = '0;
        case (alu_op_e'(ALUK))
            ALU_ADD:  alu_out = sr1_val + alu_b;
            ALU_AND:  alu_out = sr1_val & alu_b;
            ALU_NOT:  alu_out = ~sr1_val;
            ALU_PASS: alu_out = sr1_val;
            ALU_SHL:  alu_out = sr1_val << shamt;
            ALU_SHR:  alu_out = sr1_val >> shamt;
            ALU_SRA:  alu_out = W'($signed(sr1_val) >>> shamt);
            ALU_XOR:  alu_out = sr1_val ^ alu_b;
            default:  alu_out = '0;
        endcase
    end

    assign addr1 = ADDR1MUX ? sr1_val : PC;

    always_comb begin
        addr2 = '0;
        case (addr2mux_e'(ADDR2MUX))
            A2_ZERO:  addr2 = '0;
            A2_OFF6:  addr2 = sext6;
            A2_OFF9:  addr2 = sext9;
            A2_OFF11: addr2 = sext11;
            default:  addr2 = '0;
        endcase
    end

    assign addr_sum = addr1 + addr2;

    // Bus carries a source only when exactly one gate is high; otherwise zero.
    assign gates      = {GatePC, GateMDR, GateMARMUX, GateALU, GateMUL};
    assign gate_cnt   = 3'(GatePC) + 3'(GateMDR) + 3'(GateMARMUX) + 3'(GateALU) + 3'(GateMUL);
    assign multi_gate = (gate_cnt > 3'd1);

    always_comb begin
        bus = '0;
        case (gates)
            5'b10000: bus = PC;
            5'b01000: bus = MDR;
            5'b00100: bus = addr_sum;
            5'b00010: bus = alu_out;
            5'b00001: bus = mul_result;
            default:  bus = '0;
        endcase
    end

    always_comb begin
        pc_next = PC;
        case (pcmux_e'(PCMUX))
            PC_INC:  pc_next = PC + W'(1);
            PC_ADDR: pc_next = addr_sum;
            PC_BUS:  pc_next = bus;
            PC_ZERO: pc_next = '0;
            default: pc_next = PC;
        endcase
    end

    assign mdr_next = MIO_EN ? MDR_In : bus;

    always_comb begin
        cc_d = CC_POS;
        if (bus == '0) begin
            cc_d = CC_ZERO;
        end else if (bus[W-1]) begin
            cc_d = CC_NEG;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            MAR          <= '0;
            MDR          <= '0;
            PC           <= '0;
            IR           <= '0;
            cc_q         <= '0;
            BEN          <= 1'b0;
            LED          <= '0;
            BUS_CONFLICT <= 1'b0;
        end else begin
            if (LD_MAR) MAR <= bus;
            if (LD_MDR) MDR <= mdr_next;
            if (LD_PC)  PC  <= pc_next;
            if (LD_IR)  IR  <= bus;
            if (LD_CC)  cc_q <= cc_d;
            if (LD_BEN) BEN <= |(IR[11:9] & cc_q);
            if (LD_LED) LED <= IR[9:0];
            if (multi_gate) BUS_CONFLICT <= 1'b1;
        end
    end

    // Reads are asynchronous, so a same-cycle write is seen only on the next cycle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            regs <= '{default: '0};
        end else if (LD_REG) begin
            regs[dr_sel] <= bus;
        end
    end

    seq_mul #(
        .W(W)
    ) u_mul (
        .clk    (Clk),
        .rst_n  (Reset_n),
        .start  (MUL_START),
        .a      (sr1_val),
        .b      (alu_b),
        .busy   (MUL_BUSY),
        .done   (MUL_DONE),
        .result (mul_result)
    );

endmodule

// File: tb/tb_datapath_gen.sv
// Bench for datapath_gen: ALU vector table, multiplier/reset/conflict sequences,
// a W=32 instance, and randomized cycles against a behavioural model (W=16).
module tb_datapath_gen;

    localparam int unsigned W  = 16;
    localparam int unsigned WW = 32;

    logic Clk;
    logic Reset_n;
    logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
    logic GatePC, GateMDR, GateALU, GateMARMUX, GateMUL;
    logic SR2MUX, ADDR1MUX, DRMUX, SR1MUX, MIO_EN;
    logic [1:0] PCMUX, ADDR2MUX;
    logic [2:0] ALUK;
    logic MUL_START;
    logic [31:0] mdr_in;

    logic [W-1:0]  mar16, mdr16, pc16, ir16;
    logic [WW-1:0] mar32, mdr32, pc32, ir32;
    logic ben16, busy16, done16, conf16;
    logic ben32, busy32, done32, conf32;
    logic [9:0] led16, led32;

    int n_tests = 0;
    int n_fail  = 0;

    datapath_gen #(.W(W)) u_dut16 (
        .Clk(Clk), .Reset_n(Reset_n),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
        .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU),
        .GateMARMUX(GateMARMUX), .GateMUL(GateMUL),
        .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX),
        .MIO_EN(MIO_EN), .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
        .MUL_START(MUL_START), .MDR_In(mdr_in[W-1:0]),
        .MAR(mar16), .MDR(mdr16), .PC(pc16), .IR(ir16), .BEN(ben16), .LED(led16),
        .MUL_BUSY(busy16), .MUL_DONE(done16), .BUS_CONFLICT(conf16)
    );

    datapath_gen #(.W(WW)) u_dut32 (
        .Clk(Clk), .Reset_n(Reset_n),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
        .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
        .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU),
        .GateMARMUX(GateMARMUX), .GateMUL(GateMUL),
        .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX),
        .MIO_EN(MIO_EN), .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
        .MUL_START(MUL_START), .MDR_In(mdr_in),
        .MAR(mar32), .MDR(mdr32), .PC(pc32), .IR(ir32), .BEN(ben32), .LED(led32),
        .MUL_BUSY(busy32), .MUL_DONE(done32), .BUS_CONFLICT(conf32)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- behavioural model of the W=16 instance ----------------
    logic [15:0] m_regs [8];
    logic [15:0] m_mar, m_mdr, m_pc, m_ir, m_mres, m_prod;
    logic [2:0]  m_cc;
    logic        m_ben, m_busy, m_done, m_conf;
    logic [9:0]  m_led;
    int          m_cnt;

    function automatic logic [15:0] sx(input logic [15:0] v, input int n);
        logic [15:0] hi;
        hi = 16'hFFFF << n;
        return v[n-1] ? (v | hi) : (v & ~hi);
    endfunction

    function automatic logic [2:0] cc_of(input logic [15:0] v);
        if (v == 16'h0) return 3'b010;
        if (v >= 16'h8000) return 3'b100;
        return 3'b001;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = '0;
        m_mar = '0; m_mdr = '0; m_pc = '0; m_ir = '0; m_mres = '0; m_prod = '0;
        m_cc = '0; m_ben = 0; m_busy = 0; m_done = 0; m_conf = 0; m_led = '0; m_cnt = 0;
    endtask

    task automatic model_edge();
        int ng, sh;
        logic [15:0] a, b, alu, off, addr, bus, pcn;
        ng = int'(GatePC) + int'(GateMDR) + int'(GateALU) + int'(GateMARMUX) + int'(GateMUL);
        a  = m_regs[SR1MUX ? m_ir[11:9] : m_ir[8:6]];
        b  = SR2MUX ? sx(m_ir, 5) : m_regs[m_ir[2:0]];
        sh = int'(b) % 16;
        case (ALUK)
            3'd0: alu = a + b;
            3'd1: alu = a & b;
            3'd2: alu = ~a;
            3'd3: alu = a;
            3'd4: alu = a << sh;
            3'd5: alu = a >> sh;
            3'd6: alu = (a >> sh) | (a[15] ? ~(16'hFFFF >> sh) : 16'h0);
            default: alu = a ^ b;
        endcase
        case (ADDR2MUX)
            2'd0: off = 16'h0;
            2'd1: off = sx(m_ir, 6);
            2'd2: off = sx(m_ir, 9);
            default: off = sx(m_ir, 11);
        endcase
        addr = (ADDR1MUX ? a : m_pc) + off;
        bus = 16'h0;
        if (ng == 1) begin
            if (GatePC) bus = m_pc;
            else if (GateMDR) bus = m_mdr;
            else if (GateMARMUX) bus = addr;
            else if (GateALU) bus = alu;
            else bus = m_mres;
        end
        case (PCMUX)
            2'd0: pcn = m_pc + 16'd1;
            2'd1: pcn = addr;
            2'd2: pcn = bus;
            default: pcn = 16'h0;
        endcase
        if (m_busy) begin
            m_cnt--;
            m_done = 0;
            if (m_cnt == 0) begin
                m_mres = m_prod;
                m_busy = 0;
                m_done = 1;
            end
        end else begin
            m_done = 0;
            if (MUL_START) begin
                m_prod = a * b;
                m_busy = 1;
                m_cnt  = 16;
            end
        end
        if (LD_BEN) m_ben = |(m_ir[11:9] & m_cc);
        if (LD_CC)  m_cc = cc_of(bus);
        if (LD_LED) m_led = m_ir[9:0];
        if (LD_REG) m_regs[DRMUX ? m_ir[11:9] : 3'd7] = bus;
        if (LD_MAR) m_mar = bus;
        if (LD_MDR) m_mdr = MIO_EN ? mdr_in[15:0] : bus;
        if (LD_PC)  m_pc = pcn;
        if (LD_IR)  m_ir = bus;
        if (ng > 1) m_conf = 1;
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clr();
        {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED} = '0;
        {GatePC, GateMDR, GateALU, GateMARMUX, GateMUL} = '0;
        {SR2MUX, ADDR1MUX, DRMUX, SR1MUX, MIO_EN} = '0;
        PCMUX = '0; ADDR2MUX = '0; ALUK = '0; MUL_START = 0;
    endtask

    task automatic cycle();
        model_edge();
        @(posedge Clk);
        #1;
        clr();
    endtask

    function automatic logic [31:0] ins(input logic [2:0] dr, input logic [2:0] s1, input logic [2:0] s2);
        return {20'h0, dr, s1, 3'b000, s2};
    endfunction

    task automatic load_mdr(input logic [31:0] v);
        mdr_in = v; MIO_EN = 1; LD_MDR = 1; cycle();
    endtask

    task automatic load_ir(input logic [31:0] v);
        load_mdr(v); GateMDR = 1; LD_IR = 1; cycle();
    endtask

    task automatic write_reg(input logic [2:0] r, input logic [31:0] v);
        load_ir({20'h0, r, 9'h0});
        load_mdr(v);
        GateMDR = 1; DRMUX = 1; LD_REG = 1; cycle();
    endtask

    task automatic read_reg(input logic [2:0] r);
        load_ir(ins(3'd0, r, 3'd0));
        ALUK = 3'd3; GateALU = 1; LD_MAR = 1; cycle();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mar16"}, 32'(mar16), 0);  chk({tag, "_mdr16"}, 32'(mdr16), 0);
        chk({tag, "_pc16"}, 32'(pc16), 0);    chk({tag, "_ir16"}, 32'(ir16), 0);
        chk({tag, "_ben16"}, 32'(ben16), 0);  chk({tag, "_led16"}, 32'(led16), 0);
        chk({tag, "_busy16"}, 32'(busy16), 0); chk({tag, "_done16"}, 32'(done16), 0);
        chk({tag, "_conf16"}, 32'(conf16), 0);
        chk({tag, "_mar32"}, mar32, 0);       chk({tag, "_pc32"}, pc32, 0);
        chk({tag, "_ir32"}, ir32, 0);         chk({tag, "_busy32"}, 32'(busy32), 0);
        chk({tag, "_conf32"}, 32'(conf32), 0);
    endtask

    task automatic compare_model();
        chk("rnd_mar", 32'(mar16), 32'(m_mar));
        chk("rnd_mdr", 32'(mdr16), 32'(m_mdr));
        chk("rnd_pc", 32'(pc16), 32'(m_pc));
        chk("rnd_ir", 32'(ir16), 32'(m_ir));
        chk("rnd_ben", 32'(ben16), 32'(m_ben));
        chk("rnd_led", 32'(led16), 32'(m_led));
        chk("rnd_busy", 32'(busy16), 32'(m_busy));
        chk("rnd_done", 32'(done16), 32'(m_done));
        chk("rnd_conf", 32'(conf16), 32'(m_conf));
    endtask

    // Cycles until the done pulse (bounded) and how many of them showed busy.
    task automatic wait_done(input bit wide, output int n, output int nb);
        n = 0; nb = 0;
        while (n < 100 && !(wide ? done32 : done16)) begin
            if (wide ? busy32 : busy16) nb++;
            cycle();
            n++;
        end
        chk(wide ? "mul32_done_seen" : "mul16_done_seen", 32'(wide ? done32 : done16), 1);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [2:0]  cc;
    } alu_vec_t;

    alu_vec_t tbl [10];

    initial begin
        int n, nb, ndone;
        tbl[0] = '{3'd0, 16'h0005, 16'hFFFD, 16'h0002, 3'b001};
        tbl[1] = '{3'd7, 16'h0005, 16'hFFFD, 16'hFFF8, 3'b100};
        tbl[2] = '{3'd6, 16'h8000, 16'h0003, 16'hF000, 3'b100};
        tbl[3] = '{3'd1, 16'h00F0, 16'h0F0F, 16'h0000, 3'b010};
        tbl[4] = '{3'd2, 16'h00FF, 16'h0000, 16'hFF00, 3'b100};
        tbl[5] = '{3'd3, 16'h1234, 16'h0000, 16'h1234, 3'b001};
        tbl[6] = '{3'd4, 16'h0001, 16'h000F, 16'h8000, 3'b100};
        tbl[7] = '{3'd5, 16'h8000, 16'h0003, 16'h1000, 3'b001};
        tbl[8] = '{3'd4, 16'h0003, 16'h0011, 16'h0006, 3'b001};
        tbl[9] = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 3'b010};

        clr();
        mdr_in  = '0;
        Reset_n = 0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        chk_all_zero("reset");
        @(negedge Clk);
        Reset_n = 1;
        cycle();

        // CC is 000 after reset, so BEN stays 0 whatever IR holds
        load_ir(32'h0000_0E00);
        LD_BEN = 1; cycle();
        chk("ben_cc_reset", 32'(ben16), 0);

        // ALU vectors: R3 = R1 op R2, then read back and probe CC through BEN
        for (int i = 0; i < 10; i++) begin
            write_reg(3'd1, 32'(tbl[i].a));
            write_reg(3'd2, 32'(tbl[i].b));
            load_ir(ins(3'd3, 3'd1, 3'd2));
            ALUK = tbl[i].op; GateALU = 1; DRMUX = 1; LD_REG = 1; LD_CC = 1; cycle();
            read_reg(3'd3);
            chk($sformatf("alu%0d_res", i), 32'(mar16), 32'(tbl[i].res));
            load_ir({20'h0, tbl[i].cc, 9'h0});
            LD_BEN = 1; cycle();
            chk($sformatf("alu%0d_ben_hit", i), 32'(ben16), 1);
            load_ir({20'h0, ~tbl[i].cc, 9'h0});
            LD_BEN = 1; cycle();
            chk($sformatf("alu%0d_ben_miss", i), 32'(ben16), 0);
        end

        // Same-cycle write and read of one register returns the old value
        write_reg(3'd4, 32'h0000_0011);
        load_ir(ins(3'd4, 3'd4, 3'd0));
        mdr_in = 32'h0000_0077; MIO_EN = 1; LD_MDR = 1; cycle();
        ALUK = 3'd3; GateALU = 1; DRMUX = 1; LD_REG = 1; LD_MAR = 1; cycle();
        chk("rf_bypass_old", 32'(mar16), 32'h0011);

        // Multiply 7 x 6
        write_reg(3'd1, 32'd7);
        write_reg(3'd2, 32'd6);
        load_ir(ins(3'd0, 3'd1, 3'd2));
        MUL_START = 1; cycle();
        wait_done(1'b0, n, nb);
        chk("mul_latency", 32'(n), 16);
        chk("mul_busy_cycles", 32'(nb), 16);
        chk("mul_busy_at_done", 32'(busy16), 0);
        cycle();
        chk("mul_done_pulse", 32'(done16), 0);
        GateMUL = 1; LD_MAR = 1; cycle();
        chk("mul_7x6", 32'(mar16), 32'h002A);

        // 0xFFFF x 2, with a restart attempt while busy, then a restart in DONE
        write_reg(3'd1, 32'h0000_FFFF);
        write_reg(3'd2, 32'd2);
        write_reg(3'd3, 32'd3);
        load_ir(ins(3'd0, 3'd1, 3'd2));
        MUL_START = 1; cycle();
        GateMUL = 1; LD_MAR = 1; cycle();
        chk("mul_hold_while_busy", 32'(mar16), 32'h002A);
        load_ir(ins(3'd0, 3'd3, 3'd3));
        MUL_START = 1; cycle();
        wait_done(1'b0, n, nb);
        chk("mul_ignore_restart_latency", 32'(n + 4), 16);
        MUL_START = 1; GateMUL = 1; LD_MAR = 1; cycle();
        chk("mul_ffff_x2", 32'(mar16), 32'hFFFE);
        chk("mul_start_in_done", 32'(busy16), 1);
        wait_done(1'b0, n, nb);
        GateMUL = 1; LD_MAR = 1; cycle();
        chk("mul_3x3", 32'(mar16), 32'h0009);

        // Reset in the middle of a multiply
        MUL_START = 1; cycle();
        repeat (5) cycle();
        Reset_n = 0;
        #2;
        chk_all_zero("midreset");
        model_reset();
        @(negedge Clk);
        Reset_n = 1;
        cycle();
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            if (done16 || done32) ndone++;
            cycle();
        end
        chk("midreset_no_done", 32'(ndone), 0);
        read_reg(3'd1);
        chk("midreset_reg_zero", 32'(mar16), 0);

        // W=32: 0x10000 x 0x10000, 0x10000 x 3, PC + sext(0x1FF)
        write_reg(3'd1, 32'h0001_0000);
        write_reg(3'd2, 32'h0001_0000);
        load_ir(ins(3'd0, 3'd1, 3'd2));
        MUL_START = 1; cycle();
        wait_done(1'b1, n, nb);
        chk("mul32_latency", 32'(n), 32);
        GateMUL = 1; LD_MAR = 1; cycle();
        chk("mul32_wrap", mar32, 32'h0000_0000);
        write_reg(3'd2, 32'd3);
        load_ir(ins(3'd0, 3'd1, 3'd2));
        MUL_START = 1; cycle();
        wait_done(1'b1, n, nb);
        GateMUL = 1; LD_MAR = 1; cycle();
        chk("mul32_x3", mar32, 32'h0003_0000);

        load_mdr(32'h1000_0000);
        GateMDR = 1; PCMUX = 2'd2; LD_PC = 1; cycle();
        chk("pc32_load", pc32, 32'h1000_0000);
        load_ir(32'h0000_01FF);
        ADDR1MUX = 0; ADDR2MUX = 2'd2; PCMUX = 2'd1; LD_PC = 1; cycle();
        chk("pc32_minus1", pc32, 32'h0FFF_FFFF);
        chk("pc16_minus1", 32'(pc16), 32'h0000_FFFF);
        GatePC = 1; PCMUX = 2'd2; LD_PC = 1; cycle();
        chk("pc32_self_load", pc32, 32'h0FFF_FFFF);
        PCMUX = 2'd0; LD_PC = 1; cycle();
        chk("pc32_inc", pc32, 32'h1000_0000);

        // Randomized cycles with one or no gate, compared against the model
        for (int i = 0; i < 400; i++) begin
            int g;
            g = $urandom_range(0, 5);
            GatePC = (g == 0); GateMDR = (g == 1); GateALU = (g == 2);
            GateMARMUX = (g == 3); GateMUL = (g == 4);
            LD_MAR = ($urandom_range(0, 2) == 0); LD_MDR = ($urandom_range(0, 2) == 0);
            LD_IR  = ($urandom_range(0, 3) == 0); LD_BEN = ($urandom_range(0, 2) == 0);
            LD_CC  = ($urandom_range(0, 2) == 0); LD_REG = ($urandom_range(0, 1) == 0);
            LD_PC  = ($urandom_range(0, 3) == 0); LD_LED = ($urandom_range(0, 3) == 0);
            SR2MUX = 1'($urandom); ADDR1MUX = 1'($urandom); DRMUX = 1'($urandom);
            SR1MUX = 1'($urandom); MIO_EN = 1'($urandom);
            PCMUX = 2'($urandom); ADDR2MUX = 2'($urandom); ALUK = 3'($urandom);
            MUL_START = ($urandom_range(0, 7) == 0);
            mdr_in = $urandom;
            cycle();
            compare_model();
        end

        // Bus conflict: two gates at once drive zero and latch the sticky flag
        load_mdr(32'h0000_1234);
        GateMDR = 1; LD_MAR = 1; cycle();
        chk("conf_pre_mar", 32'(mar16), 32'h1234);
        chk("conf_pre_flag", 32'(conf16), 0);
        GatePC = 1; GateALU = 1; LD_MAR = 1; cycle();
        chk("conf_bus_zero", 32'(mar16), 0);
        chk("conf_flag", 32'(conf16), 1);
        repeat (10) cycle();
        chk("conf_sticky", 32'(conf16), 1);
        chk("conf_model", 32'(conf16), 32'(m_conf));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
